// File: rtl/led_blink_bank.sv
// Multi-channel LED pattern generator: per-channel phase accumulators
// driving off/on/blink/PWM LEDs, with a run-time write port, a global
// phase sync and per-channel wrap pulses.
module led_blink_bank #(
  parameter int unsigned      N_CH      = 4,
  parameter int unsigned      ACC_W     = 32,
  parameter int unsigned      DUTY_W    = 8,
  parameter logic [ACC_W-1:0] RESET_INC = ACC_W'(215),
  localparam int unsigned     CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync_i,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_mode,
  input  logic [ACC_W-1:0]  wr_inc,
  input  logic [DUTY_W-1:0] wr_duty,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   wrap,
  output logic              wr_err
);

  localparam logic [1:0]        MODE_OFF   = 2'd0;
  localparam logic [1:0]        MODE_ON    = 2'd1;
  localparam logic [1:0]        MODE_BLINK = 2'd2;
  localparam logic [DUTY_W-1:0] DUTY_RST   = DUTY_W'(1) << (DUTY_W - 1);

  // Per-channel configuration and phase state
  logic [ACC_W-1:0]  acc  [N_CH];
  logic [ACC_W-1:0]  inc  [N_CH];
  logic [1:0]        mode [N_CH];
  logic [DUTY_W-1:0] duty [N_CH];

  logic              wr_ok;
  logic [N_CH-1:0]   wr_sel;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   carry;
  logic [N_CH-1:0]   led_nxt;
  logic [ACC_W:0]    sum [N_CH];

  // Write decode, clear priority, accumulator add with carry and LED function
  always_comb begin
    wr_ok   = wr_en && (32'(wr_ch) < N_CH);
    wr_sel  = '0;
    clr     = '0;
    carry   = '0;
    led_nxt = '0;
    for (int c = 0; c < N_CH; c++) begin
      sum[c]    = (ACC_W+1)'(acc[c]) + (ACC_W+1)'(inc[c]);
      carry[c]  = sum[c][ACC_W];
      wr_sel[c] = wr_ok && (wr_ch == CH_W'(c));
      clr[c]    = sync_i || wr_sel[c];
      case (mode[c])
        MODE_OFF:   led_nxt[c] = 1'b0;
        MODE_ON:    led_nxt[c] = 1'b1;
        MODE_BLINK: led_nxt[c] = acc[c][ACC_W-1];
        default:    led_nxt[c] = (acc[c][ACC_W-1 -: DUTY_W] < duty[c]);
      endcase
    end
  end

  // Accumulators advance every cycle unless cleared; valid writes load config
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        acc[c]  <= '0;
        inc[c]  <= RESET_INC;
        mode[c] <= MODE_BLINK;
        duty[c] <= DUTY_RST;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        acc[c] <= clr[c] ? '0 : sum[c][ACC_W-1:0];
        if (wr_sel[c]) begin
          inc[c]  <= wr_inc;
          mode[c] <= wr_mode;
          duty[c] <= wr_duty;
        end
      end
    end
  end

  // Registered outputs; a cleared accumulator suppresses its wrap pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led    <= '0;
      wrap   <= '0;
      wr_err <= 1'b0;
    end else begin
      led    <= led_nxt;
      wrap   <= carry & ~clr;
      wr_err <= wr_en && !wr_ok;
    end
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank with an 8-bit accumulator and 3 channels so that
// blink/PWM periods are short and an out-of-range channel exists.
module tb_led_blink_bank;

  localparam int NCH  = 3;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int RINC = 37;
  localparam longint MOD = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sync_i = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [1:0]    wr_mode = '0;
  logic [AW-1:0] wr_inc = '0;
  logic [DW-1:0] wr_duty = '0;
  logic [NCH-1:0] led;
  logic [NCH-1:0] wrap;
  logic          wr_err;

  int checks = 0;
  int passed = 0;

  // Reference model: phase is (cycles since last clear) * inc modulo 2^AW
  longint   t_m    [NCH];
  longint   inc_m  [NCH];
  int       mode_m [NCH];
  longint   duty_m [NCH];
  logic [NCH-1:0] exp_led;
  logic [NCH-1:0] exp_wrap;
  logic           exp_err;

  led_blink_bank #(
    .N_CH(NCH), .ACC_W(AW), .DUTY_W(DW), .RESET_INC(AW'(RINC))
  ) dut (
    .clk(clk), .reset(reset), .sync_i(sync_i), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_mode(wr_mode), .wr_inc(wr_inc), .wr_duty(wr_duty),
    .led(led), .wrap(wrap), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      t_m[c] = 0; inc_m[c] = RINC; mode_m[c] = 2; duty_m[c] = 128;
    end
    exp_led = '0; exp_wrap = '0; exp_err = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs at that edge
  task automatic step();
    logic   ok;
    logic   cl;
    longint a;
    @(posedge clk);
    ok = wr_en && (int'(wr_ch) < NCH);
    exp_err = wr_en && !ok;
    for (int c = 0; c < NCH; c++) begin
      a = (t_m[c] * inc_m[c]) % MOD;
      case (mode_m[c])
        0:       exp_led[c] = 1'b0;
        1:       exp_led[c] = 1'b1;
        2:       exp_led[c] = (a >= MOD / 2);
        default: exp_led[c] = (a < duty_m[c]);
      endcase
      cl = sync_i || (ok && int'(wr_ch) == c);
      exp_wrap[c] = !cl && (((t_m[c] + 1) * inc_m[c]) / MOD != (t_m[c] * inc_m[c]) / MOD);
      if (cl) t_m[c] = 0;
      else    t_m[c] = t_m[c] + 1;
    end
    if (ok) begin
      inc_m[int'(wr_ch)]  = longint'(wr_inc);
      mode_m[int'(wr_ch)] = int'(wr_mode);
      duty_m[int'(wr_ch)] = longint'(wr_duty);
    end
    #1;
  endtask

  task automatic do_write(input int ch, input int md, input int inc, input int dt);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_mode = 2'(md); wr_inc = AW'(inc); wr_duty = DW'(dt);
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    checks++;
    if (led !== '0 || wrap !== '0 || wr_err !== 1'b0)
      $display("FAIL reset_por led=%b wrap=%b err=%b required 0", led, wrap, wr_err);
    else passed++;
    model_reset();
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (led !== exp_led || wrap !== exp_wrap || wr_err !== exp_err)
        $display("FAIL reset_blink cyc%0d led=%b/%b wrap=%b/%b err=%b/%b", i, led, exp_led, wrap, exp_wrap, wr_err, exp_err);
      else passed++;
    end
    do_write(0, 1, 5, 0);
    step(); step();
    checks++;
    if (led[0] !== 1'b1 || led !== exp_led)
      $display("FAIL reset_pre_led led=%b required %b", led, exp_led);
    else passed++;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (led !== '0 || wrap !== '0 || wr_err !== 1'b0)
      $display("FAIL reset_async led=%b wrap=%b err=%b required 0", led, wrap, wr_err);
    else passed++;
    model_reset();
    @(negedge clk); @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (led !== exp_led || wrap !== exp_wrap || wr_err !== exp_err)
        $display("FAIL reset_after cyc%0d led=%b/%b wrap=%b/%b err=%b/%b", i, led, exp_led, wrap, exp_wrap, wr_err, exp_err);
      else passed++;
    end
  endtask

  task automatic test_blink();
    int nwrap = 0;
    do_write(0, 2, 64, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      nwrap += int'(wrap[0]);
      checks++;
      if (led[0] !== logic'(((i - 1) % 4) >= 2) || led !== exp_led || wrap !== exp_wrap)
        $display("FAIL blink cyc%0d led=%b/%b wrap=%b/%b", i, led, exp_led, wrap, exp_wrap);
      else passed++;
    end
    checks++;
    if (nwrap !== 4) $display("FAIL blink_wraps got %0d required 4", nwrap);
    else passed++;
  endtask

  task automatic test_pwm();
    int duties [3] = '{64, 0, 255};
    for (int k = 0; k < 3; k++) begin
      int cnt = 0;
      do_write(1, 3, 1, duties[k]);
      for (int i = 0; i < 256; i++) begin
        step();
        cnt += int'(led[1]);
        checks++;
        if (led !== exp_led || wrap !== exp_wrap)
          $display("FAIL pwm_d%0d cyc%0d led=%b/%b wrap=%b/%b", duties[k], i, led, exp_led, wrap, exp_wrap);
        else passed++;
      end
      checks++;
      if (cnt !== duties[k]) $display("FAIL pwm_count duty=%0d high=%0d required %0d", duties[k], cnt, duties[k]);
      else passed++;
    end
  endtask

  task automatic test_sync();
    do_write(0, 2, 16, 0);
    for (int i = 0; i < 3; i++) step();
    do_write(1, 2, 16, 0);
    for (int i = 0; i < 5; i++) step();
    do_write(2, 2, 16, 0);
    for (int i = 0; i < 2 + int'($urandom_range(0, 5)); i++) step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    checks++;
    if (wrap !== '0 || led !== exp_led)
      $display("FAIL sync_edge wrap=%b required 000 led=%b/%b", wrap, led, exp_led);
    else passed++;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (led !== exp_led || wrap !== exp_wrap || led !== {NCH{led[0]}})
        $display("FAIL sync_align cyc%0d led=%b/%b wrap=%b/%b", i, led, exp_led, wrap, exp_wrap);
      else passed++;
    end
  endtask

  task automatic test_bad_channel();
    wr_en = 1'b1; wr_ch = 2'd3; wr_mode = 2'($urandom); wr_inc = AW'($urandom); wr_duty = DW'($urandom);
    step();
    checks++;
    if (wr_err !== 1'b1 || led !== exp_led || wrap !== exp_wrap)
      $display("FAIL bad_single err=%b required 1 led=%b/%b wrap=%b/%b", wr_err, led, exp_led, wrap, exp_wrap);
    else passed++;
    step();
    wr_en = 1'b0;
    step();
    checks++;
    if (wr_err !== 1'b0 || led !== exp_led || wrap !== exp_wrap)
      $display("FAIL bad_pulse_end err=%b required 0 led=%b/%b", wr_err, led, exp_led);
    else passed++;
    wr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (wr_err !== 1'b1 || led !== exp_led || wrap !== exp_wrap)
        $display("FAIL bad_b2b cyc%0d err=%b required 1", i, wr_err);
      else passed++;
    end
    wr_en = 1'b0;
    do_write(2, 3, 9, 100);
    checks++;
    if (wr_err !== 1'b0 || led !== exp_led || wrap !== exp_wrap)
      $display("FAIL good_write err=%b required 0 led=%b/%b wrap=%b/%b", wr_err, led, exp_led, wrap, exp_wrap);
    else passed++;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (led !== exp_led || wrap !== exp_wrap || wr_err !== exp_err)
        $display("FAIL good_run cyc%0d led=%b/%b wrap=%b/%b", i, led, exp_led, wrap, exp_wrap);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    do_write(1, 2, 64, 0);
    for (int i = 0; i < 3; i++) step();
    do_write(1, 1, 64, 0);
    checks++;
    if (wrap[1] !== 1'b0 || wrap !== exp_wrap)
      $display("FAIL simul_wrap wrap=%b required %b", wrap, exp_wrap);
    else passed++;
    step();
    checks++;
    if (led[1] !== 1'b1 || led !== exp_led)
      $display("FAIL simul_mode led=%b required %b", led, exp_led);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sync_i  = ($urandom_range(0, 15) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_ch   = 2'($urandom);
      wr_mode = 2'($urandom);
      wr_inc  = AW'($urandom);
      wr_duty = DW'($urandom);
      step();
      checks++;
      if (led !== exp_led || wrap !== exp_wrap || wr_err !== exp_err)
        $display("FAIL random cyc%0d led=%b/%b wrap=%b/%b err=%b/%b", i, led, exp_led, wrap, exp_wrap, wr_err, exp_err);
      else passed++;
    end
    sync_i = 1'b0;
    wr_en  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_blink();
    test_pwm();
    test_sync();
    test_bad_channel();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
